// File: rtl/param_fifo_if.sv
// Request/status bundle for param_fifo. The fifo is the slave side and the producer/consumer is the master side.
interface param_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              iPush;
  logic [DATA_W-1:0] iWrData;
  logic              iPop;
  logic              iClrErr;
  logic [DATA_W-1:0] oRdData;
  logic              oFull;
  logic              oEmpty;
  logic              oAlmostFull;
  logic              oAlmostEmpty;
  logic [ADDR_W:0]   oCount;
  logic              oOverflow;
  logic              oUnderflow;

  modport master (
    output iPush, iWrData, iPop, iClrErr,
    input  oRdData, oFull, oEmpty, oAlmostFull, oAlmostEmpty, oCount, oOverflow, oUnderflow
  );

  modport slave (
    input  iPush, iWrData, iPop, iClrErr,
    output oRdData, oFull, oEmpty, oAlmostFull, oAlmostEmpty, oCount, oOverflow, oUnderflow
  );
endinterface

// File: rtl/param_fifo.sv
// Show-ahead synchronous FIFO. It uses extra-MSB pointers, threshold flags and sticky overflow/underflow errors.
module param_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic         iClk,
  input  logic         iRst_n,
  param_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              full, empty, push_acc, pop_acc;

  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign count = wr_ptr_q - rd_ptr_q;

  // When the fifo is full, a push is accepted only if a pop frees the head slot on the same edge.
  assign pop_acc  = bus.iPop & ~empty;
  assign push_acc = bus.iPush & (~full | pop_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push_acc};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop_acc};
    ovf_d    = (ovf_q & ~bus.iClrErr) | (bus.iPush & ~push_acc);
    unf_d    = (unf_q & ~bus.iClrErr) | (bus.iPop & empty);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is intentionally not reset. A push seen while reset is held is dropped.
  always_ff @(posedge iClk) begin
    if (iRst_n && push_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.iWrData;
  end

  assign bus.oRdData      = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign bus.oFull        = full;
  assign bus.oEmpty       = empty;
  assign bus.oCount       = count;
  assign bus.oAlmostFull  = (count >= (ADDR_W+1)'(AFULL_TH));
  assign bus.oAlmostEmpty = (count <= (ADDR_W+1)'(AEMPTY_TH));
  assign bus.oOverflow    = ovf_q;
  assign bus.oUnderflow   = unf_q;
endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo at DATA_W=8, ADDR_W=4, AFULL_TH=14, AEMPTY_TH=2.
module tb_param_fifo;
  logic iClk = 1'b0;
  logic iRst_n;
  int   nchk = 0;
  int   nerr = 0;
  logic [7:0] q[$];

  param_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus();

  param_fifo #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests and return 1 time unit after the rising edge.
  task automatic cyc(input logic p, input logic [7:0] d, input logic r, input logic c);
    bus.iPush = p; bus.iWrData = d; bus.iPop = r; bus.iClrErr = c;
    @(posedge iClk); #1;
    bus.iPush = 1'b0; bus.iPop = 1'b0; bus.iClrErr = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cnt"},   32'(bus.oCount), 0);
    chk({tag, "_empty"}, 32'(bus.oEmpty), 1);
    chk({tag, "_full"},  32'(bus.oFull), 0);
    chk({tag, "_ae"},    32'(bus.oAlmostEmpty), 1);
    chk({tag, "_af"},    32'(bus.oAlmostFull), 0);
    chk({tag, "_ovf"},   32'(bus.oOverflow), 0);
    chk({tag, "_unf"},   32'(bus.oUnderflow), 0);
  endtask

  initial begin
    logic [7:0] d;
    bus.iPush = 0; bus.iWrData = 0; bus.iPop = 0; bus.iClrErr = 0;
    iRst_n = 1'b0;
    #2;
    chk_idle("rst");
    repeat (2) @(posedge iClk);
    @(negedge iClk); iRst_n = 1'b1;

    // Fill 0x00..0x0F, watching the threshold crossings.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0, 0);
      if (i == 1)  chk("ae_at2",  32'(bus.oAlmostEmpty), 1);
      if (i == 2)  chk("ae_at3",  32'(bus.oAlmostEmpty), 0);
      if (i == 12) chk("af_at13", 32'(bus.oAlmostFull), 0);
      if (i == 13) chk("af_at14", 32'(bus.oAlmostFull), 1);
    end
    chk("fill_full", 32'(bus.oFull), 1);
    chk("fill_cnt",  32'(bus.oCount), 16);
    chk("fill_head", 32'(bus.oRdData), 8'h00);

    // Overflow: a rejected push leaves the queue untouched.
    cyc(1, 8'hAA, 0, 0);
    chk("ovf_set",  32'(bus.oOverflow), 1);
    chk("ovf_cnt",  32'(bus.oCount), 16);
    chk("ovf_head", 32'(bus.oRdData), 8'h00);
    cyc(1, 8'hAA, 0, 1);
    chk("ovf_clr_vs_new", 32'(bus.oOverflow), 1);
    cyc(0, 0, 0, 1);
    chk("ovf_clr", 32'(bus.oOverflow), 0);

    // Drain in order. The 0xAA pushes must not appear.
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(bus.oRdData), 32'(i));
      cyc(0, 0, 1, 0);
      if (i == 2) chk("af_at13_dn", 32'(bus.oAlmostFull), 0);
    end
    chk("drain_empty", 32'(bus.oEmpty), 1);
    chk("drain_cnt",   32'(bus.oCount), 0);
    chk("drain_unf",   32'(bus.oUnderflow), 0);

    // Underflow: on an empty fifo, push+pop keeps only the push.
    cyc(1, 8'h55, 1, 0);
    chk("unf_set",  32'(bus.oUnderflow), 1);
    chk("unf_cnt",  32'(bus.oCount), 1);
    chk("unf_data", 32'(bus.oRdData), 8'h55);
    cyc(0, 0, 0, 1);
    chk("unf_clr", 32'(bus.oUnderflow), 0);
    cyc(0, 0, 1, 0);
    chk("unf_empty", 32'(bus.oEmpty), 1);

    // Full pass-through: 0x77 lands in the freed slot and exits last.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    chk("pt_full", 32'(bus.oFull), 1);
    cyc(1, 8'h77, 1, 0);
    chk("pt_cnt", 32'(bus.oCount), 16);
    chk("pt_ovf", 32'(bus.oOverflow), 0);
    for (int j = 0; j < 16; j++) begin
      chk("pt_data", 32'(bus.oRdData), (j < 15) ? 32'(8'h11 + j) : 32'h77);
      cyc(0, 0, 1, 0);
    end
    chk("pt_empty", 32'(bus.oEmpty), 1);

    // Interleaved traffic across a pointer wrap, checked against a queue model.
    q.delete();
    for (int i = 0; i < 40; i++) begin
      logic p, r;
      p = (i % 4) != 3;
      r = (i % 4) != 0;
      d = 8'(8'h80 + i);
      if (q.size() > 0) chk("wrap_head", 32'(bus.oRdData), 32'(q[0]));
      cyc(p, d, r, 0);
      if (r && q.size() > 0) void'(q.pop_front());
      if (p) q.push_back(d);
      chk("wrap_cnt", 32'(bus.oCount), 32'(q.size()));
    end
    chk("wrap_unf", 32'(bus.oUnderflow), 0);

    // Asynchronous reset mid-period discards queued words.
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h03, 0, 0);
    chk("pre_rst_cnt", 32'(bus.oCount), 3);
    #2 iRst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    cyc(1, 8'hEE, 1, 0);
    chk("rst_ignore_cnt", 32'(bus.oCount), 0);
    @(negedge iClk); iRst_n = 1'b1;
    cyc(1, 8'h3C, 0, 0);
    chk("post_rst_cnt",  32'(bus.oCount), 1);
    chk("post_rst_data", 32'(bus.oRdData), 8'h3C);
    chk("post_rst_addr0", 32'(dut.mem_q[0]), 8'h3C);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits, legal range 1..64.
REQ-002 Parameter ADDR_W, default 4: address width; depth is 2**ADDR_W, legal range 2..10.
REQ-003 Parameter AFULL_TH, default 14: oAlmostFull asserts when count >= AFULL_TH, legal range 1..depth.
REQ-004 Parameter AEMPTY_TH, default 2: oAlmostEmpty asserts when count <= AEMPTY_TH, legal range 0..depth-1.
REQ-005 iClk  input  1  single clock; all state updates on its rising edge.
REQ-006 iRst_n  input  1  reset; asynchronous and active-low.
REQ-007 iPush  input  1  write request.
REQ-008 iWrData  input  DATA_W  write data, sampled with iPush.
REQ-009 iPop  input  1  read request.
REQ-010 oRdData  output  DATA_W  head-of-queue word (show-ahead).
REQ-011 oFull / oEmpty  output  1 each  occupancy equals depth / zero.
REQ-012 oAlmostFull / oAlmostEmpty  output  1 each  threshold flags.
REQ-013 oCount  output  ADDR_W+1  current occupancy, 0..depth.
REQ-014 iClrErr  input  1  synchronous clear of sticky error flags.
REQ-015 oOverflow / oUnderflow  output  1 each  sticky error flags.

Function
REQ-016 Storage: internal array of depth x DATA_W, written on accepted push at the write pointer's low ADDR_W bits.
REQ-017 Pointers: write and read pointers of ADDR_W+1 bits; each increments by 1 on acceptance and wraps modulo 2**(ADDR_W+1).
REQ-018 Full: pointer MSBs differ and low ADDR_W bits are equal; empty: pointers equal; both flags are derived from registered pointers, with no separate flag registers.
REQ-019 oCount: write pointer minus read pointer, computed modulo 2**(ADDR_W+1).
REQ-020 Push acceptance: iPush and (not oFull, or iPop accepted in the same cycle).
REQ-021 Pop acceptance: iPop and not oEmpty.
REQ-022 Simultaneous push+pop while full: both accepted; oCount stays at depth; the new word is written into the slot being freed.
REQ-023 Simultaneous push+pop while empty: push only; the pop is rejected and oUnderflow is set.
REQ-024 Simultaneous push+pop, neither full nor empty: both accepted; oCount unchanged.
REQ-025 Latency: a word pushed at edge N appears on oRdData after edge N when it becomes head; oEmpty deasserts after the same edge N.
REQ-026 oRdData: combinational read of the array at the read pointer; value is don't-care while oEmpty=1.
REQ-027 Rejected push (iPush=1, full, no accepted pop) leaves storage and pointers unchanged and sets oOverflow on that edge.
REQ-028 Rejected pop (iPop=1, empty) leaves pointers unchanged and sets oUnderflow on that edge.
REQ-029 oOverflow / oUnderflow stay at 1 until iClrErr=1 is sampled.
REQ-030 Same-edge clear and new error: the new error wins and the flag reads 1.
REQ-031 oAlmostFull and oAlmostEmpty are combinational compares of oCount against the parameters.

Reset
REQ-032 iRst_n=0 immediately, without waiting for a clock, forces: both pointers to 0, oCount=0, oEmpty=1, oFull=0, oAlmostEmpty=1, oAlmostFull=0, oOverflow=0, oUnderflow=0.
REQ-033 Reset does not clear storage contents.
REQ-034 Reset asserted mid-operation discards all queued words.
REQ-035 The first push after iRst_n rises writes address 0.
REQ-036 Push and pop requests are ignored on any edge where iRst_n=0.

Verification (DATA_W=8, ADDR_W=4, AFULL_TH=14, AEMPTY_TH=2)
REQ-037 Fill and drain: push 0x00..0x0F -> oFull=1, oCount=16; then 16 pops -> oRdData shows 0x00..0x0F in order, oEmpty=1 at the end.
REQ-038 Thresholds: push 3 words -> oAlmostEmpty=0; push to 14 words -> oAlmostFull=1; push to 13 words -> oAlmostFull=0.
REQ-039 Overflow: when full, push 0xAA without pop -> oOverflow=1, oCount=16, contents unchanged; iClrErr pulse -> oOverflow=0.
REQ-040 Underflow: when empty, push 0x55 with pop in the same cycle -> oUnderflow=1, oCount=1, oRdData=0x55.
REQ-041 Full pass-through: when full, push 0x77 with pop -> oCount=16; 0x77 is read out as the 16th word after the remaining 15 older words.
REQ-042 Wrap and reset: 40 interleaved push/pop cycles to wrap the pointers, with data order preserved; then drop iRst_n mid-clock-period -> oEmpty=1 and oCount=0 immediately.
